// File: rtl/coin_input_cond.sv
// coin_input_cond: synchronizes and debounces coin/cancel inputs and arbitrates a single pending-coin slot.
//   clk, rst                      : clock, asynchronous active-high reset
//   dollar_raw/fifty_raw/cancel_raw : asynchronous sensor/button levels
//   insert_coin                   : downstream FSM ready to take the held coin
//   dollar/fifty/cancel           : one-cycle accepted-event pulses
//   coin_reject                   : one-cycle eject command
//   pending                       : a coin is held in the slot
module coin_input_cond #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dollar_raw,
    input  logic fifty_raw,
    input  logic cancel_raw,
    input  logic insert_coin,
    output logic dollar,
    output logic fifty,
    output logic cancel,
    output logic coin_reject,
    output logic pending
);
    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [2:0] raw, sync1, sync2, ev;
    logic c_ev, rej_q, slot_v, slot_t, freed, avail, load, coin_ev;
    assign raw = {cancel_raw, fifty_raw, dollar_raw};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end
    // channel 0 = dollar, 1 = fifty, 2 = cancel; an event fires once on entry to HELD
    for (genvar g = 0; g < 3; g++) begin : ch
        state_t state, state_n;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic hit;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt <= '0;
            end else begin
                state <= state_n;
                cnt <= cnt_n;
            end
        end
        always_comb begin
            state_n = state;
            cnt_n = cnt;
            hit = 1'b0;
            case (state)
                IDLE: if (sync2[g]) begin
                    state_n = ARM;
                    cnt_n = ONE;
                end
                ARM: if (!sync2[g]) state_n = IDLE;
                    else if (cnt == LAST) begin
                        state_n = HELD;
                        hit = 1'b1;
                    end else cnt_n = cnt + 1'b1;
                HELD: if (!sync2[g]) begin
                    state_n = REL;
                    cnt_n = ONE;
                end
                REL: if (sync2[g]) state_n = HELD;
                    else if (cnt == LAST) state_n = IDLE;
                    else cnt_n = cnt + 1'b1;
                default: state_n = IDLE;
            endcase
        end
        assign ev[g] = hit;
    end
    // the slot is freed by a release or by a cancel, so a coin arriving on that edge can take it
    assign freed = slot_v & (c_ev | insert_coin);
    assign avail = !slot_v | freed;
    assign coin_ev = ev[0] | ev[1];
    assign load = coin_ev & avail;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ev <= 1'b0;
            rej_q <= 1'b0;
            slot_v <= 1'b0;
            slot_t <= 1'b0;
            dollar <= 1'b0;
            fifty <= 1'b0;
            cancel <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            c_ev <= ev[2];
            rej_q <= (ev[0] & ev[1]) | (coin_ev & !avail);
            slot_v <= load | (slot_v & !freed);
            slot_t <= load ? ev[0] : slot_t;
            dollar <= !c_ev & slot_v & insert_coin & slot_t;
            fifty <= !c_ev & slot_v & insert_coin & !slot_t;
            cancel <= c_ev;
            coin_reject <= rej_q | (c_ev & slot_v);
        end
    end
    assign pending = slot_v;
endmodule
